captura_operandos: RTL

Keypad-side operand entry block for the arithmetic path: it collects decimal digits from the keypad scanner, builds two binary operands, and drives the adder's `num1`, `num2` and `suma_btn` inputs. It sits between the keypad decoder and the adder, acting as the writer for the operand interface the adder reads.

---
 rtl/captura_operandos.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/captura_operandos.sv
// Keypad operand capture: builds num1/num2 from decimal digits and pulses suma_btn.
// Optional CAPTURA_SYNC_EDGE_EN: synchronize key_valid as a level and act on its rising edge.
module captura_operandos #(
    parameter int MAX_DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    output logic [11:0] num1,
    output logic [11:0] num2,
    output logic        suma_btn,
    output logic [1:0]  estado,
    output logic [1:0]  digitos
);

    typedef enum logic [1:0] {
        ENTRADA1 = 2'b00,
        ENTRADA2 = 2'b01,
        LISTO    = 2'b10
    } estado_t;

    localparam logic [1:0] MAX_D = 2'(MAX_DIGITS);

    logic        key_ev;
    logic [3:0]  key_cd;

`ifdef CAPTURA_SYNC_EDGE_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q, edge_d;

    always_comb begin
        sync1_d = key_valid;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    assign key_ev = sync2_q & ~edge_q;
`else
    assign key_ev = key_valid;
`endif

    assign key_cd = key_code;

    estado_t     estado_q, estado_d;
    logic [11:0] num1_q, num1_d;
    logic [11:0] num2_q, num2_d;
    logic        suma_q, suma_d;
    logic [1:0]  dig_q, dig_d;

    logic        is_digit;
    logic        key_a;
    logic        key_b;
    logic        key_c;
    logic [11:0] op;
    logic [11:0] op_next;

    assign is_digit = (key_cd <= 4'd9);
    assign key_a    = (key_cd == 4'hA);
    assign key_b    = (key_cd == 4'hB);
    assign key_c    = (key_cd == 4'hC);

    // operand*10 + d as shift-add, 12-bit wrap
    assign op      = (estado_q == ENTRADA2) ? num2_q : num1_q;
    assign op_next = (op << 3) + (op << 1) + {8'd0, key_cd};

    always_comb begin
        estado_d = estado_q;
        num1_d   = num1_q;
        num2_d   = num2_q;
        dig_d    = dig_q;
        suma_d   = 1'b0;
        case (estado_q)
            ENTRADA1, ENTRADA2: begin
                if (key_ev) begin
                    unique case (1'b1)
                        is_digit: begin
                            if (dig_q < MAX_D) begin
                                if (estado_q == ENTRADA1) num1_d = op_next;
                                else                      num2_d = op_next;
                                dig_d = dig_q + 2'd1;
                            end
                        end
                        key_a: begin
                            if (dig_q != 2'd0) begin
                                if (estado_q == ENTRADA1) begin
                                    estado_d = ENTRADA2;
                                    dig_d    = 2'd0;
                                end else begin
                                    estado_d = LISTO;
                                end
                            end
                        end
                        key_c: begin
                            num1_d   = 12'd0;
                            num2_d   = 12'd0;
                            dig_d    = 2'd0;
                            estado_d = ENTRADA1;
                        end
                        default: ;
                    endcase
                end
            end
            LISTO: begin
                if (key_ev) begin
                    unique case (1'b1)
                        is_digit: begin
                            num1_d   = {8'd0, key_cd};
                            num2_d   = 12'd0;
                            dig_d    = 2'd1;
                            estado_d = ENTRADA1;
                        end
                        key_b: suma_d = 1'b1;
                        key_c: begin
                            num1_d   = 12'd0;
                            num2_d   = 12'd0;
                            dig_d    = 2'd0;
                            estado_d = ENTRADA1;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                num1_d   = 12'd0;
                num2_d   = 12'd0;
                dig_d    = 2'd0;
                estado_d = ENTRADA1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= ENTRADA1;
            num1_q   <= 12'd0;
            num2_q   <= 12'd0;
            dig_q    <= 2'd0;
            suma_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
            dig_q    <= dig_d;
            suma_q   <= suma_d;
        end
    end

    assign num1     = num1_q;
    assign num2     = num2_q;
    assign suma_btn = suma_q;
    assign estado   = estado_q;
    assign digitos  = dig_q;

endmodule
